// File: rtl/reg_file.sv
// Three-port register file for the single-cycle MIPS core.
// Two combinational read ports feed the ALU operands. One write port commits at
// the rising clock edge. A debug read port always shows the stored contents.
// A saturating counter records how many writes have been committed.
module reg_file #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int BYPASS    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] ra1,
    input  logic [ADDR_BITS-1:0] ra2,
    output logic [WIDTH-1:0]     rd1,
    output logic [WIDTH-1:0]     rd2,
    input  logic                 RegWrite,
    input  logic [ADDR_BITS-1:0] wa,
    input  logic [WIDTH-1:0]     wd,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [WIDTH-1:0]     dbg_data,
    output logic [15:0]          wr_count
);

    localparam int NREGS = 1 << ADDR_BITS;

    logic [WIDTH-1:0] r_mem [NREGS];
    logic [15:0]      r_wr_count;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd1_stored;
    logic [WIDTH-1:0] w_rd2_stored;

    // A write commits only when enabled, not aimed at r0, and reset is low.
    // Gating with reset also keeps the forwarding path quiet during reset.
    assign w_wr_en = RegWrite && (wa != '0) && !reset;

    // Storage and write counter. Reset clears everything at once, independent of the clock.
    // r0 is cleared by reset and never written afterwards, so it stays constant zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_wr_en) begin
            r_mem[wa] <= wd;
            if (r_wr_count != 16'hFFFF) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    // Combinational reads. r0 reads as zero. Optional forwarding of the write
    // data is only for pipelined reuse: with a single-cycle core it would close
    // the loop rd -> ALU -> wd.
    always_comb begin
        w_rd1_stored = (ra1 == '0) ? '0 : r_mem[ra1];
        w_rd2_stored = (ra2 == '0) ? '0 : r_mem[ra2];
        rd1 = w_rd1_stored;
        rd2 = w_rd2_stored;
        if ((BYPASS != 0) && w_wr_en && (ra1 == wa)) begin
            rd1 = wd;
        end
        if ((BYPASS != 0) && w_wr_en && (ra2 == wa)) begin
            rd2 = wd;
        end
    end

    // The debug port always shows the stored value. It is never forwarded.
    always_comb begin
        dbg_data = (dbg_addr == '0) ? '0 : r_mem[dbg_addr];
    end

    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file. Two instances share all inputs: one with forwarding
// disabled and one with forwarding enabled. The driver pushes expected values
// (with an output selector) into a queue and raises an event. A monitor process
// pops each entry and compares it against the selected DUT output.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra1, ra2, wa, dbg_addr;
  logic        RegWrite;
  logic [31:0] wd;
  logic [31:0] rd1_0, rd2_0, dbg_0, rd1_b, rd2_b, dbg_b;
  logic [15:0] cnt_0, cnt_b;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  int          total = 0;
  int          bad = 0;
  event        sample_ev;
  logic [31:0] wd_seq;
  logic [31:0] vi, vj;

  // clock / reset block
  always #5 clk = ~clk;

  reg_file #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(0)) u_dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
    .RegWrite(RegWrite), .wa(wa), .wd(wd), .dbg_addr(dbg_addr),
    .dbg_data(dbg_0), .wr_count(cnt_0)
  );

  reg_file #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(1)) u_dut_byp (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .RegWrite(RegWrite), .wa(wa), .wd(wd), .dbg_addr(dbg_addr),
    .dbg_data(dbg_b), .wr_count(cnt_b)
  );

  localparam int S_RD1 = 0, S_RD2 = 1, S_DBG = 2, S_CNT = 3;
  localparam int S_RD1_B = 4, S_RD2_B = 5, S_DBG_B = 6, S_CNT_B = 7;

  function automatic logic [31:0] get_actual(input int sel);
    case (sel)
      S_RD1:   return rd1_0;
      S_RD2:   return rd2_0;
      S_DBG:   return dbg_0;
      S_CNT:   return {16'h0, cnt_0};
      S_RD1_B: return rd1_b;
      S_RD2_B: return rd2_b;
      S_DBG_B: return dbg_b;
      default: return {16'h0, cnt_b};
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_RD1:   return "rd1";
      S_RD2:   return "rd2";
      S_DBG:   return "dbg_data";
      S_CNT:   return "wr_count";
      S_RD1_B: return "byp_rd1";
      S_RD2_B: return "byp_rd2";
      S_DBG_B: return "byp_dbg_data";
      default: return "byp_wr_count";
    endcase
  endfunction

  // driver tasks
  task automatic expect_val(input int sel, input logic [31:0] v);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  task automatic check_now();
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    RegWrite = 1'b1;
    wa = a;
    wd = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic burst_r1(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      RegWrite = 1'b1;
      wa = 5'd1;
      wd = wd_seq;
      wd_seq = wd_seq + 32'd1;
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [31:0] e, act;
    int s;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        act = get_actual(s);
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s actual=%h expected=%h at %0t", sel_name(s), act, e, $time);
        end
      end
    end
  end

  // watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    reset = 1'b1;
    RegWrite = 1'b0;
    wa = '0;
    wd = '0;
    ra1 = 5'd4;
    ra2 = 5'd9;
    dbg_addr = 5'd4;
    wd_seq = 32'h1000_0000;

    // reset state
    expect_val(S_RD1, 32'h0);
    expect_val(S_RD2, 32'h0);
    expect_val(S_DBG, 32'h0);
    expect_val(S_CNT, 32'h0);
    expect_val(S_CNT_B, 32'h0);
    check_now();
    @(negedge clk);
    reset = 1'b0;

    // reset clears immediately without a clock edge
    do_write(5'd5, 32'hDEAD_BEEF);
    ra1 = 5'd5;
    dbg_addr = 5'd5;
    expect_val(S_RD1, 32'hDEAD_BEEF);
    expect_val(S_DBG, 32'hDEAD_BEEF);
    expect_val(S_CNT, 32'd1);
    check_now();
    reset = 1'b1;
    expect_val(S_RD1, 32'h0);
    expect_val(S_DBG, 32'h0);
    expect_val(S_CNT, 32'h0);
    expect_val(S_RD1_B, 32'h0);
    check_now();
    reset = 1'b0;

    // basic write and read on both ports
    do_write(5'd3, 32'h0000_00A5);
    ra1 = 5'd3;
    ra2 = 5'd3;
    expect_val(S_RD1, 32'h0000_00A5);
    expect_val(S_RD2, 32'h0000_00A5);
    expect_val(S_CNT, 32'd1);
    check_now();

    // r0 write is discarded and not counted
    do_write(5'd0, 32'hFFFF_FFFF);
    ra1 = 5'd0;
    dbg_addr = 5'd0;
    expect_val(S_RD1, 32'h0);
    expect_val(S_DBG, 32'h0);
    expect_val(S_RD1_B, 32'h0);
    expect_val(S_CNT, 32'd1);
    check_now();

    // RegWrite low holds state
    @(negedge clk);
    wa = 5'd3;
    wd = 32'h1234_5678;
    @(posedge clk);
    #1;
    ra1 = 5'd3;
    expect_val(S_RD1, 32'h0000_00A5);
    expect_val(S_CNT, 32'd1);
    check_now();

    // same-cycle read/write hazard
    do_write(5'd7, 32'd10);
    @(negedge clk);
    RegWrite = 1'b1;
    wa = 5'd7;
    wd = 32'd20;
    ra1 = 5'd7;
    ra2 = 5'd6;
    dbg_addr = 5'd7;
    expect_val(S_RD1, 32'd10);
    expect_val(S_RD1_B, 32'd20);
    expect_val(S_DBG_B, 32'd10);
    expect_val(S_RD2_B, 32'h0);
    check_now();
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    expect_val(S_RD1, 32'd20);
    expect_val(S_RD1_B, 32'd20);
    expect_val(S_DBG, 32'd20);
    expect_val(S_CNT, 32'd3);
    check_now();

    // full sweep after a fresh reset
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      vi = i;
      do_write(vi[4:0], vi * 32'h0101_0101);
    end
    for (int i = 1; i < 32; i++) begin
      vi = i;
      vj = 32 - i;
      ra1 = vi[4:0];
      ra2 = vj[4:0];
      dbg_addr = vj[4:0];
      expect_val(S_RD1, vi * 32'h0101_0101);
      expect_val(S_RD2, vj * 32'h0101_0101);
      expect_val(S_DBG, vj * 32'h0101_0101);
      check_now();
    end
    ra1 = 5'd0;
    ra2 = 5'd31;
    expect_val(S_RD1, 32'h0);
    expect_val(S_RD2, 32'h1F1F_1F1F);
    expect_val(S_CNT, 32'd31);
    expect_val(S_CNT_B, 32'd31);
    check_now();

    // counter saturation: 65540 writes to r1 on top of 31
    burst_r1(65503);
    expect_val(S_CNT, 32'h0000_FFFE);
    check_now();
    burst_r1(1);
    expect_val(S_CNT, 32'h0000_FFFF);
    expect_val(S_CNT_B, 32'h0000_FFFF);
    check_now();
    burst_r1(36);
    ra1 = 5'd1;
    expect_val(S_CNT, 32'h0000_FFFF);
    expect_val(S_CNT_B, 32'h0000_FFFF);
    expect_val(S_RD1, 32'h1000_0000 + 32'd65539);
    check_now();

    #2;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
